adder_arbiter: RTL

Shares a single n-bit ripple-carry adder (the team's `ripple_carry_adder`, carry-in fixed at 0) between two requesters. Each requester has a valid/ready port. The block arbitrates round-robin and registers the sum, carry-out and winning requester ID into a one-entry output stage with its own valid/ready handshake. It sits between operand producers and a single downstream consumer. It provides one result per cycle at full throughput and fair access under contention.

---
 rtl/adder_arbiter.sv | 85 ++++++++
 1 files changed

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one n-bit ripple-carry adder between two requesters,
// with a one-entry registered result stage (sum, carry-out, winning requester id).
module adder_arbiter #(
   parameter int n = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [n-1:0] req0_a,
   input  logic [n-1:0] req0_b,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [n-1:0] req1_a,
   input  logic [n-1:0] req1_b,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [n-1:0] res_sum,
   output logic         res_cout,
   output logic         res_id
);

   // Handshake: a transfer happens on any port when valid && ready at a rising
   // clk edge; producers hold valid and operands stable until that edge.
   logic         last;
   logic         slot_free;
   logic         grant_any;
   logic         grant;
   logic         accept;
   logic [n-1:0] op_a;
   logic [n-1:0] op_b;
   logic [n-1:0] add_sum;
   logic         add_cout;

   assign slot_free = !res_valid || res_ready;

   // With both requesters valid the one that did not win last time goes next.
   always_comb begin
      grant_any = req0_valid || req1_valid;
      grant     = 1'b0;
      if (req0_valid && req1_valid) begin
         grant = !last;
      end else if (req1_valid) begin
         grant = 1'b1;
      end
   end

   assign req0_ready = slot_free && grant_any && !grant && !rst;
   assign req1_ready = slot_free && grant_any &&  grant && !rst;
   assign accept     = req0_ready || req1_ready;

   assign op_a = grant ? req1_a : req0_a;
   assign op_b = grant ? req1_b : req0_b;

   // Ripple-carry chain, carry-in tied to zero.
   always_comb begin : ripple
      logic c;
      add_sum = '0;
      c       = 1'b0;
      for (int i = 0; i < n; i++) begin
         add_sum[i] = op_a[i] ^ op_b[i] ^ c;
         c          = (op_a[i] & op_b[i]) | (c & (op_a[i] ^ op_b[i]));
      end
      add_cout = c;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_valid <= 1'b0;
         res_sum   <= '0;
         res_cout  <= 1'b0;
         res_id    <= 1'b0;
         last      <= 1'b1;
      end else if (accept) begin
         res_valid <= 1'b1;
         res_sum   <= add_sum;
         res_cout  <= add_cout;
         res_id    <= grant;
         last      <= grant;
      end else if (res_ready) begin
         res_valid <= 1'b0;
      end
   end

endmodule
